// File: rtl/cov_tst_chan.sv
// cov_tst_chan: multi-channel coverage test block.
// A two-state handshake (IDLE/EXEC) accepts one sample every two cycles and
// applies one of four update rules (ADJUST, ACC, HOLD, CLEAR) to a selected
// channel register. Any channel can be read back through a registered port.
module cov_tst_chan #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int HI_THRESH = 100,
    parameter int LO_THRESH = 70,
    parameter int LOAD_VAL  = 21
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(CHANNELS):0]     ch_sel,
    input  logic [1:0]                    mode,
    input  logic [$clog2(CHANNELS)-1:0]   rd_sel,
    output logic [WIDTH-1:0]              out,
    output logic                          done,
    output logic                          err,
    output logic [CHANNELS-1:0]           sat
);

    localparam int CW = $clog2(CHANNELS);

    // Thresholds and load constant are taken modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] HI_VAL   = WIDTH'(HI_THRESH);
    localparam logic [WIDTH-1:0] LO_VAL   = WIDTH'(LO_THRESH);
    localparam logic [WIDTH-1:0] LOAD_CST = WIDTH'(LOAD_VAL);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADJUST = 2'd0,
        MODE_ACC    = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_CLEAR  = 2'd3
    } mode_t;

    state_t               state_q;
    state_t               state_d;

    logic [WIDTH-1:0]     x_q;
    logic [CW:0]          chSel_q;
    mode_t                mode_q;

    logic [WIDTH-1:0]     chan_q [CHANNELS];
    logic [CHANNELS-1:0]  sat_q;
    logic [WIDTH-1:0]     out_q;

    logic                 writeEn;
    logic                 chLegal;
    logic [CW-1:0]        chIdx;
    logic [WIDTH-1:0]     curVal;
    logic [WIDTH-1:0]     newVal;
    logic [WIDTH:0]       accSum;
    logic                 satSet;
    logic                 satClr;
    logic                 parity;

    // Channel count is a power of two, so the top select bit alone marks
    // an out-of-range channel.
    assign chLegal = ~chSel_q[CW];
    assign chIdx   = chSel_q[CW-1:0];
    assign curVal  = chan_q[chIdx];
    assign parity  = ^x_q;

    // State register: reset returns to IDLE and aborts any pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a sample is accepted in IDLE, EXEC always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: ready only in IDLE; done/err mark the EXEC cycle unless reset kills it.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        writeEn  = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            EXEC: begin
                done    = ~rst;
                err     = ~rst & ~chLegal;
                writeEn = ~rst & chLegal;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Capture the sample, target channel and mode on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            chSel_q <= '0;
            mode_q  <= MODE_ADJUST;
        end else if (state_q == IDLE && in_valid) begin
            x_q     <= in;
            chSel_q <= ch_sel;
            mode_q  <= mode_t'(mode);
        end
    end

    // Update rule: computes the channel's next value and saturation flag action.
    always_comb begin
        newVal = curVal;
        satSet = 1'b0;
        satClr = 1'b0;
        accSum = {1'b0, curVal} + {1'b0, x_q};
        case (mode_q)
            MODE_ADJUST: begin
                if (x_q[WIDTH-1]) begin
                    if (curVal > HI_VAL) begin
                        newVal = x_q;
                    end else begin
                        newVal = -x_q;
                    end
                end else if (x_q < LO_VAL) begin
                    newVal = LOAD_CST;
                end else begin
                    newVal = curVal;
                end
                newVal[0] = parity;
            end
            MODE_ACC: begin
                if (accSum[WIDTH]) begin
                    newVal = '1;
                    satSet = 1'b1;
                end else begin
                    newVal = accSum[WIDTH-1:0];
                end
            end
            MODE_HOLD: begin
                newVal = curVal;
            end
            MODE_CLEAR: begin
                newVal = '0;
                satClr = 1'b1;
            end
            default: newVal = curVal;
        endcase
    end

    // Channel registers: only the selected legal channel is written at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                chan_q[i] <= '0;
            end
        end else if (writeEn) begin
            chan_q[chIdx] <= newVal;
        end
    end

    // Sticky saturation flags: set by an overflowing ACC, cleared by CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= '0;
        end else if (writeEn) begin
            if (satSet) begin
                sat_q[chIdx] <= 1'b1;
            end else if (satClr) begin
                sat_q[chIdx] <= 1'b0;
            end
        end
    end

    // Read-back register samples the channel array before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= chan_q[rd_sel];
        end
    end

    assign out = out_q;
    assign sat = sat_q;

endmodule

// File: tb/tb_cov_tst_chan.sv
// Testbench for cov_tst_chan: directed cases plus randomized traffic checked
// against an arithmetic reference model of the channel update rules. A second
// instance with WIDTH=12, CHANNELS=8 exercises a wider parameter set.
module tb_cov_tst_chan;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int W2 = 12;
    localparam int N2 = 8;

    logic          clk = 1'b0;
    logic          rst;

    logic [W-1:0]  inData;
    logic          inValid;
    logic          inReady;
    logic [2:0]    chSel;
    logic [1:0]    mode;
    logic [1:0]    rdSel;
    logic [W-1:0]  outData;
    logic          done;
    logic          err;
    logic [N-1:0]  sat;

    logic [W2-1:0] inData2;
    logic          inValid2;
    logic          inReady2;
    logic [3:0]    chSel2;
    logic [1:0]    mode2;
    logic [2:0]    rdSel2;
    logic [W2-1:0] outData2;
    logic          done2;
    logic          err2;
    logic [N2-1:0] sat2;

    int            testsRun    = 0;
    int            testsFailed = 0;

    int            chanRef  [N];
    bit            satRef   [N];
    int            chanRef2 [N2];
    bit            satRef2  [N2];

    cov_tst_chan #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (inData),
        .in_valid (inValid),
        .in_ready (inReady),
        .ch_sel   (chSel),
        .mode     (mode),
        .rd_sel   (rdSel),
        .out      (outData),
        .done     (done),
        .err      (err),
        .sat      (sat)
    );

    cov_tst_chan #(.WIDTH(W2), .CHANNELS(N2)) dutWide (
        .clk      (clk),
        .rst      (rst),
        .in       (inData2),
        .in_valid (inValid2),
        .in_ready (inReady2),
        .ch_sel   (chSel2),
        .mode     (mode2),
        .rd_sel   (rdSel2),
        .out      (outData2),
        .done     (done2),
        .err      (err2),
        .sat      (sat2)
    );

    always #5 clk = ~clk;

    // Reference rule for one update, expressed with plain integer arithmetic modulo 2^w.
    function automatic int refNext(input int w, input int r, input int x, input int md,
                                   inout bit satFlag);
        int full;
        int res;
        full = 1 << w;
        res  = r;
        case (md)
            0: begin
                if (x >= full / 2) begin
                    res = (r > (100 % full)) ? x : (full - x) % full;
                end else if (x < (70 % full)) begin
                    res = 21 % full;
                end else begin
                    res = r;
                end
                res = res - (res % 2) + ($countones(x) % 2);
            end
            1: begin
                if (r + x >= full) begin
                    res     = full - 1;
                    satFlag = 1'b1;
                end else begin
                    res = r + x;
                end
            end
            2: res = r;
            default: begin
                res     = 0;
                satFlag = 1'b0;
            end
        endcase
        return res;
    endfunction

    function automatic int satVec();
        int v = 0;
        for (int i = 0; i < N; i++) if (satRef[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int satVec2();
        int v = 0;
        for (int i = 0; i < N2; i++) if (satRef2[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic resetModels();
        for (int i = 0; i < N; i++) begin
            chanRef[i] = 0;
            satRef[i]  = 1'b0;
        end
        for (int i = 0; i < N2; i++) begin
            chanRef2[i] = 0;
            satRef2[i]  = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read one channel back on the narrow instance and compare with the model.
    task automatic verifyChannel(input int c);
        rdSel = c[1:0];
        @(posedge clk); #1;
        checkOutput($sformatf("out ch%0d", c), outData, chanRef[c]);
        checkOutput("sat", sat, satVec());
    endtask

    task automatic verifyAll();
        for (int c = 0; c < N; c++) verifyChannel(c);
    endtask

    // One full transaction on the narrow instance: accept, EXEC, back to IDLE, read back.
    task automatic applyStimulus(input int ch, input int md, input int x);
        int waitCnt = 0;
        bit legal;
        while (!inReady && waitCnt < 10) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("ready", inReady, 1);
        inData  = x[W-1:0];
        chSel   = ch[2:0];
        mode    = md[1:0];
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        inData  = W'($urandom);
        chSel   = 3'($urandom);
        mode    = 2'($urandom);
        legal   = (ch < N);
        checkOutput("done", done, 1);
        checkOutput("err", err, legal ? 0 : 1);
        checkOutput("busy", inReady, 0);
        if (legal) chanRef[ch] = refNext(W, chanRef[ch], x, md, satRef[ch]);
        @(posedge clk); #1;
        checkOutput("donePulse", done, 0);
        if (legal) verifyChannel(ch);
        else       verifyAll();
    endtask

    // One full transaction on the wide instance.
    task automatic applyStimulusWide(input int ch, input int md, input int x);
        int waitCnt = 0;
        while (!inReady2 && waitCnt < 10) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("ready2", inReady2, 1);
        inData2  = x[W2-1:0];
        chSel2   = ch[3:0];
        mode2    = md[1:0];
        inValid2 = 1'b1;
        @(posedge clk); #1;
        inValid2 = 1'b0;
        checkOutput("done2", done2, 1);
        checkOutput("err2", err2, (ch < N2) ? 0 : 1);
        if (ch < N2) chanRef2[ch] = refNext(W2, chanRef2[ch], x, md, satRef2[ch]);
        @(posedge clk); #1;
        if (ch < N2) begin
            rdSel2 = ch[2:0];
            @(posedge clk); #1;
            checkOutput($sformatf("out2 ch%0d", ch), outData2, chanRef2[ch]);
        end
        checkOutput("sat2", sat2, satVec2());
    endtask

    initial begin
        rst      = 1'b1;
        inValid  = 1'b1;
        inData   = 8'hA5;
        chSel    = 3'd1;
        mode     = 2'd1;
        rdSel    = 2'd0;
        inValid2 = 1'b0;
        inData2  = '0;
        chSel2   = '0;
        mode2    = '0;
        rdSel2   = '0;
        resetModels();

        // Reset held two cycles with a valid sample present.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkOutput("rstDone", done, 0);
            checkOutput("rstOut", outData, 0);
            checkOutput("rstSat", sat, 0);
        end
        inValid = 1'b0;
        rst     = 1'b0;
        checkOutput("rstReady", inReady, 1);
        verifyAll();

        // ADJUST sequence on channel 0.
        applyStimulus(0, 0, 'h85);
        checkOutput("adj 0x85", outData, 'h7B);
        applyStimulus(0, 0, 'h90);
        checkOutput("adj 0x90", outData, 'h90);
        applyStimulus(0, 0, 'h10);
        checkOutput("adj 0x10", outData, 'h15);
        applyStimulus(0, 0, 'h50);
        checkOutput("adj 0x50", outData, 'h14);

        // Saturating accumulate and clear on channel 2.
        applyStimulus(2, 1, 'h80);
        applyStimulus(2, 1, 'h70);
        checkOutput("acc 0xF0", outData, 'hF0);
        applyStimulus(2, 1, 'h20);
        checkOutput("acc sat", outData, 'hFF);
        checkOutput("sat[2] set", sat[2], 1);
        applyStimulus(2, 3, 'h00);
        checkOutput("clear", outData, 'h00);
        checkOutput("sat[2] clr", sat[2], 0);

        // Illegal channel select: done and err only, nothing written.
        applyStimulus(4, 1, 'h55);

        // Continuous valid for six cycles: only every other sample is taken.
        applyStimulus(3, 3, 0);
        inValid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int d;
            d      = $urandom_range(1, 60);
            inData = d[W-1:0];
            chSel  = 3'd3;
            mode   = 2'd1;
            @(posedge clk); #1;
            checkOutput($sformatf("hsDone%0d", k), done, (k % 2 == 0) ? 1 : 0);
            if (k % 2 == 0) chanRef[3] = refNext(W, chanRef[3], d, 1, satRef[3]);
        end
        inValid = 1'b0;
        verifyChannel(3);

        // Randomized traffic including illegal selects and all modes.
        for (int t = 0; t < 40; t++) begin
            applyStimulus($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 255));
        end

        // Reset during EXEC aborts the write of 0x33 to channel 1.
        applyStimulus(1, 3, 0);
        inData  = 8'h33;
        chSel   = 3'd1;
        mode    = 2'd1;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        rst     = 1'b1;
        #1;
        checkOutput("abortDone", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        resetModels();
        checkOutput("abortReady", inReady, 1);
        verifyAll();

        // Wide parameter set: ADJUST on the top channel, then random traffic.
        applyStimulusWide(7, 0, 'h805);
        for (int t = 0; t < 15; t++) begin
            applyStimulusWide($urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 4095));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
